// File: rtl/jpeg_buffer_pkg.sv
// jpeg_buffer_pkg
// Shared types and constants for the JPEG buffer sink: the controller state
// enum, word/byte-lane geometry and two small helpers used by the datapath.
// No ports.
package jpeg_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE,
    READOUT
  } buffer_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_WIDTH     = 8;
  localparam int WORD_WIDTH     = BYTES_PER_WORD * BYTE_WIDTH;
  localparam int LANE_BITS      = $clog2(BYTES_PER_WORD);

  // Byte 0 of a stored word lives in the least significant lane.
  function automatic logic [BYTE_WIDTH-1:0] select_lane(
    input logic [WORD_WIDTH-1:0] word,
    input logic [LANE_BITS-1:0]  lane
  );
    return word[BYTE_WIDTH*lane +: BYTE_WIDTH];
  endfunction

  // One past the last byte covered by a word written at this address,
  // clamped so a write near the top of the 16-bit space cannot wrap to a
  // small image size.
  function automatic logic [15:0] saturating_end(input logic [15:0] address);
    logic [16:0] sum;
    sum = {1'b0, address} + 17'd4;
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/jpeg_buffer_sink_if.sv
// jpeg_buffer_sink_if
// Bundles the encoder word-write bus and the byte readout stream.
//   data_in/address_in/data_valid_in : encoder -> sink, one word per strobe
//   byte_out/byte_valid_out/byte_last_out : sink -> consumer
//   byte_ready_in : consumer -> sink, accepts the presented byte
// master : encoder and consumer side; slave : the buffer sink.
interface jpeg_buffer_sink_if;

  logic [31:0] data_in;
  logic [15:0] address_in;
  logic        data_valid_in;
  logic [7:0]  byte_out;
  logic        byte_valid_out;
  logic        byte_ready_in;
  logic        byte_last_out;

  modport master (
    output data_in, address_in, data_valid_in, byte_ready_in,
    input  byte_out, byte_valid_out, byte_last_out
  );

  modport slave (
    input  data_in, address_in, data_valid_in, byte_ready_in,
    output byte_out, byte_valid_out, byte_last_out
  );

endinterface

// File: rtl/jpeg_buffer_ram.sv
// jpeg_buffer_ram
// Simple dual-port word RAM with one write port and one registered read port
// (one cycle of read latency), written so it maps onto block RAM. Contents
// have no reset.
//   clock_in      : clock
//   write_enable  : write write_data to write_address
//   write_address : word address of the write
//   write_data    : word to store
//   read_enable   : load read_data from read_address at the next edge
//   read_address  : word address of the read
//   read_data     : registered read result, holds while read_enable is low
module jpeg_buffer_ram
  import jpeg_buffer_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock_in,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [WORD_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [WORD_WIDTH-1:0] read_data
);

  logic [WORD_WIDTH-1:0] memory [DEPTH];

  always_ff @(posedge clock_in) begin
    if (write_enable) begin
      memory[write_address] <= write_data;
    end
    if (read_enable) begin
      read_data <= memory[read_address];
    end
  end

endmodule

// File: rtl/jpeg_buffer_sink.sv
// jpeg_buffer_sink
// Receiving end of the JPEG encoder output. Captures 32-bit words into an
// on-chip RAM at the byte address supplied with each word, tracks the image
// size and completion, and replays the stored image as a byte stream with a
// valid/ready handshake for the SPI readout path.
//   clock_in, reset_in  : clock and synchronous active-high reset
//   capture_start_in    : pulse, clear status and arm capture
//   image_valid_in      : level, encoder has finished the image
//   read_start_in       : pulse, (re)start readout from byte 0
//   bus                 : encoder write bus and byte readout stream
//   image_size_out      : highest written byte address + 4, saturated
//   image_ready_out     : image captured and readable
//   overflow_out        : sticky, a write fell outside the buffer
//   protocol_error_out  : sticky, data_valid_in high on consecutive cycles
// BUFFER_BYTES must be a power of two and at least 8.
module jpeg_buffer_sink
  import jpeg_buffer_pkg::*;
#(
  parameter int BUFFER_BYTES = 16384,
  parameter int AW           = $clog2(BUFFER_BYTES)
) (
  input  logic                clock_in,
  input  logic                reset_in,
  input  logic                capture_start_in,
  input  logic                image_valid_in,
  input  logic                read_start_in,
  jpeg_buffer_sink_if.slave   bus,
  output logic [15:0]         image_size_out,
  output logic                image_ready_out,
  output logic                overflow_out,
  output logic                protocol_error_out
);

  localparam int          WORD_DEPTH = BUFFER_BYTES / BYTES_PER_WORD;
  localparam int          WAW        = AW - LANE_BITS;
  localparam logic [16:0] CAPACITY   = 17'(BUFFER_BYTES);

  buffer_state_t   state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_next, last_index;
  logic [7:0]      byte_q;
  logic            byte_valid_q;
  logic [15:0]     size_q;
  logic            ready_q, overflow_q, protocol_error_q;
  logic            prev_valid_q, data_arrived_q;
  logic [16:0]     limit;
  logic            in_range, write_enable, read_enable, read_restart;
  logic            accept, is_last;
  logic [WAW-1:0]  read_word;
  logic [31:0]     read_data;
  logic [15:0]     write_end;

  // Readable length is the recorded size clipped to what the RAM can hold,
  // so an overflowed image still replays its in-range part.
  assign limit      = ({1'b0, size_q} >= CAPACITY) ? CAPACITY : {1'b0, size_q};
  assign last_index = AW'(limit - 17'd1);
  assign ptr_next   = ptr_q + AW'(1);
  assign is_last    = (ptr_q == last_index);
  assign accept     = byte_valid_q && bus.byte_ready_in;
  assign write_end  = saturating_end(bus.address_in);

  assign in_range     = ({1'b0, bus.address_in} < CAPACITY);
  assign write_enable = !reset_in && (state_q == CAPTURE) && bus.data_valid_in && in_range;

  jpeg_buffer_ram #(
    .DEPTH      (WORD_DEPTH),
    .ADDR_WIDTH (WAW)
  ) u_ram (
    .clock_in      (clock_in),
    .write_enable  (write_enable),
    .write_address (bus.address_in[AW-1:LANE_BITS]),
    .write_data    (bus.data_in),
    .read_enable   (read_enable),
    .read_address  (read_word),
    .read_data     (read_data)
  );

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The RAM read for the next byte is issued in the same cycle as the event
  // that needs it (start or acceptance), so data lands one edge later and
  // the byte register loads on the edge after that.
  always_comb begin
    state_d      = state_q;
    read_enable  = 1'b0;
    read_restart = 1'b0;
    read_word    = ptr_next[AW-1:LANE_BITS];
    if (capture_start_in) begin
      state_d = CAPTURE;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        CAPTURE: if (image_valid_in) state_d = DONE;
        DONE: begin
          if (read_start_in && (limit != 17'd0)) begin
            state_d      = READOUT;
            read_restart = 1'b1;
          end
        end
        READOUT: begin
          if (read_start_in) begin
            read_restart = 1'b1;
          end else if (accept) begin
            if (is_last) state_d = DONE;
            else read_enable = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (read_restart) begin
      read_enable = 1'b1;
      read_word   = '0;
    end
  end

  // Status and readout datapath. A capture start from any state clears the
  // image status and drops an in-flight byte.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      ptr_q            <= '0;
      byte_q           <= '0;
      byte_valid_q     <= 1'b0;
      size_q           <= '0;
      ready_q          <= 1'b0;
      overflow_q       <= 1'b0;
      protocol_error_q <= 1'b0;
      prev_valid_q     <= 1'b0;
      data_arrived_q   <= 1'b0;
    end else begin
      data_arrived_q <= read_enable;
      if (capture_start_in) begin
        ptr_q            <= '0;
        byte_valid_q     <= 1'b0;
        size_q           <= '0;
        ready_q          <= 1'b0;
        overflow_q       <= 1'b0;
        protocol_error_q <= 1'b0;
        prev_valid_q     <= 1'b0;
      end else begin
        case (state_q)
          CAPTURE: begin
            prev_valid_q <= bus.data_valid_in;
            if (bus.data_valid_in) begin
              if (write_end > size_q) size_q <= write_end;
              if (!in_range) overflow_q <= 1'b1;
              if (prev_valid_q) protocol_error_q <= 1'b1;
            end
            if (image_valid_in) ready_q <= 1'b1;
          end
          DONE, READOUT: begin
            if (read_restart) begin
              ptr_q        <= '0;
              byte_valid_q <= 1'b0;
            end else if (state_q == READOUT) begin
              if (accept) begin
                ptr_q        <= ptr_next;
                byte_valid_q <= 1'b0;
              end else if (data_arrived_q && !byte_valid_q) begin
                byte_valid_q <= 1'b1;
                byte_q       <= select_lane(read_data, ptr_q[LANE_BITS-1:0]);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.byte_out        = byte_q;
  assign bus.byte_valid_out  = byte_valid_q;
  assign bus.byte_last_out   = byte_valid_q && is_last;
  assign image_size_out      = size_q;
  assign image_ready_out     = ready_q;
  assign overflow_out        = overflow_q;
  assign protocol_error_out  = protocol_error_q;

endmodule

// File: doc/jpeg_buffer_sink.md
Name: jpeg_buffer_sink

Overview:
- Receiving end of the JPEG encoder output interface.
- Captures 32-bit compressed words into an on-chip word RAM at the byte address supplied with each word.
- Latches image size and completion.
- Serves the stored image back out as a byte stream with valid/ready handshake, for the SPI readout path.
- Sits between the encoder and the SPI register/readout logic, in the same clock domain as the encoder output.

Parameters:
- BUFFER_BYTES, 16384, capacity in bytes; must be a power of two and a multiple of 4. Word depth is BUFFER_BYTES/4.
- AW, $clog2(BUFFER_BYTES), byte-address width used internally.

Ports:
- clock_in  input  1  single clock, same domain as the encoder output.
- reset_in  input  1  synchronous, active-high reset.
- capture_start_in  input  1  one-cycle pulse: clear buffer state and arm capture.
- data_in  input  32  encoded word; byte 0 of the word is data_in[7:0].
- address_in  input  16  byte address of data_in; word aligned.
- data_valid_in  input  1  qualifies data_in/address_in. Never high two consecutive cycles.
- image_valid_in  input  1  level; high once compression has finished.
- read_start_in  input  1  pulse: begin byte readout from byte 0.
- byte_out  output  8  readout byte.
- byte_valid_out  output  1  byte_out valid.
- byte_ready_in  input  1  consumer accepts byte_out when high with byte_valid_out.
- byte_last_out  output  1  high with the final byte of the image.
- image_size_out  output  16  image size in bytes.
- image_ready_out  output  1  image captured and readable.
- overflow_out  output  1  sticky: a write fell outside the buffer.
- protocol_error_out  output  1  sticky: data_valid_in high two consecutive cycles.

Behaviour:
- Reset values:
  - state IDLE
  - byte_out 0, byte_valid_out 0, byte_last_out 0
  - image_size_out 0, image_ready_out 0
  - overflow_out 0, protocol_error_out 0
- FSM states: IDLE, CAPTURE, DONE, READOUT.
- IDLE:
  - capture_start_in -> CAPTURE.
  - Writes are ignored.
- CAPTURE:
  - On entry, clear image_size_out, overflow_out, protocol_error_out and image_ready_out.
  - Each data_valid_in cycle writes data_in to RAM word address_in[AW-1:2] in the same cycle.
  - image_size_out <= max(image_size_out, address_in+4), computed 17-bit and saturated to 16'hFFFF.
  - If address_in >= BUFFER_BYTES, drop the write and set overflow_out; image_size_out still updates.
  - address_in[1:0] != 0: ignore the low bits (word write at truncated address).
  - data_valid_in in two consecutive cycles: write both words and set protocol_error_out.
  - image_valid_in high -> DONE next cycle, with image_ready_out=1. A data_valid_in in that same cycle is still written.
- DONE:
  - read_start_in -> READOUT; the internal read pointer is cleared to 0.
  - capture_start_in -> CAPTURE.
  - read_start_in and capture_start_in together: capture wins.
- READOUT:
  - RAM read latency is 1 cycle.
  - The first byte_valid_out rises exactly 2 cycles after read_start_in.
  - byte_out = word[8*ptr[1:0] +: 8].
  - byte_out and byte_valid_out are held stable until byte_ready_in.
  - Each accepted byte advances ptr; the next byte is valid no later than 2 cycles after acceptance. Back-to-back (1 byte per cycle) via prefetch is permitted but not required.
  - byte_last_out = byte_valid_out & (ptr == min(image_size_out, BUFFER_BYTES) - 1).
  - Acceptance of the last byte -> DONE with byte_valid_out 0.
  - image_size_out == 0: read_start_in returns to DONE with no bytes emitted.
  - read_start_in while in READOUT restarts from byte 0.
  - capture_start_in aborts the readout: byte_valid_out drops next cycle, state -> CAPTURE.
- Reset in any state returns to IDLE within one cycle. RAM contents are not cleared.
- image_ready_out remains 1 through DONE and READOUT and clears only on capture_start_in or reset.

Decomposition:
- Package jpeg_buffer_pkg holds:
  - state enum
  - BYTES_PER_WORD = 4
  - word/byte-lane helper constants
- One sub-module, jpeg_buffer_ram:
  - simple dual-port, one write port and one read port
  - registered read, 1-cycle latency
  - inferred to EBR

Test Plan:
1. Basic capture and readout:
   - Stimulus: capture_start_in; words 0x44332211@0, 0x88776655@4, each followed by an idle cycle; image_valid_in; read_start_in, ready always high.
   - Required: image_size_out=8; bytes 11,22,33,44,55,66,77,88; byte_last_out only on 0x88; first byte_valid_out 2 cycles after read_start_in.
2. Backpressure:
   - Stimulus: byte_ready_in toggles 1-of-3 cycles during readout.
   - Required: byte_out is stable while valid & !ready; no byte is duplicated or skipped.
3. Overflow:
   - Stimulus: BUFFER_BYTES=16; write @12, then @16.
   - Required: overflow_out=1; image_size_out=20; readout emits 16 bytes, last byte = byte 15.
4. Protocol error:
   - Stimulus: data_valid_in high 2 consecutive cycles (@0, @4).
   - Required: protocol_error_out=1; both words are stored.
5. Abort and re-capture:
   - Stimulus: capture_start_in mid-readout.
   - Required: byte_valid_out=0 next cycle; image_ready_out=0; image_size_out=0; a new image captures and reads correctly.
6. Reset mid-CAPTURE:
   - Stimulus: reset_in asserted during capture.
   - Required: all outputs return to reset values next cycle; data_valid_in is ignored until capture_start_in.
